// File: rtl/param_sync_fifo_if.sv
// Handshake and status bundle between a single-clock FIFO and its producer/consumer.
// The master modport is the user side; the slave modport is the FIFO itself.
interface param_sync_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_rq;
    logic [WIDTH-1:0] wdata;
    logic             rd_rq;
    logic             err_clr;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_rq, wdata, rd_rq, err_clr,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_rq, wdata, rd_rq, err_clr,
        output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered count, threshold flags, sticky error flags
// and a choice of registered-read or first-word-fall-through output.
module param_sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic              clk,
    input logic              rst,
    param_sync_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf, udf;
    logic             full_w, empty_w, wr_acc, rd_acc;

    assign full_w  = (cnt == CW'(DEPTH));
    assign empty_w = (cnt == '0);
    // Acceptance looks only at the registered flags, so a read never makes
    // room for a same-cycle write and vice versa.
    assign wr_acc  = bus.wr_rq && !full_w;
    assign rd_acc  = bus.rd_rq && !empty_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc)      cnt <= cnt + 1'b1;
            else if (rd_acc && !wr_acc) cnt <= cnt - 1'b1;
            // A new error in the same cycle as err_clr keeps the flag set.
            if (bus.wr_rq && full_w)  ovf <= 1'b1;
            else if (bus.err_clr)     ovf <= 1'b0;
            if (bus.rd_rq && empty_w) udf <= 1'b1;
            else if (bus.err_clr)     udf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr] <= bus.wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Masked while empty so the unreset array never shows on rdata.
            assign bus.rdata  = empty_w ? '0 : mem[rd_ptr];
            assign bus.rvalid = !empty_w;
        end else begin : g_std
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem[rd_ptr];
                end
            end
            assign bus.rdata  = rdata_q;
            assign bus.rvalid = rvalid_q;
        end
    endgenerate

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (cnt >= CW'(AF_LEVEL));
    assign bus.almost_empty = (cnt <= CW'(AE_LEVEL));
    assign bus.count        = cnt;
    assign bus.overflow     = ovf;
    assign bus.underflow    = udf;
endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: a standard-mode FIFO (a) and an FWFT FIFO (b), both 8x16, AF=14, AE=2.
module tb_param_sync_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) a ();
    param_sync_fifo_if #(.WIDTH(8), .DEPTH(16)) b ();

    param_sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut_std (
        .clk(clk), .rst(rst), .bus(a.slave)
    );
    param_sync_fifo #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .bus(b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [7:0] d);
        a.wr_rq = 1'b1; a.wdata = d; tick(); a.wr_rq = 1'b0;
    endtask

    task automatic rd_a(input logic [7:0] exp, input string tag);
        a.rd_rq = 1'b1; tick(); a.rd_rq = 1'b0;
        chk({tag, "_rvalid"}, 32'(a.rvalid), 32'd1);
        chk({tag, "_rdata"}, 32'(a.rdata), 32'(exp));
    endtask

    initial begin
        a.wr_rq = 0; a.rd_rq = 0; a.err_clr = 0; a.wdata = 0;
        b.wr_rq = 0; b.rd_rq = 0; b.err_clr = 0; b.wdata = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset values
        chk("rst_count", 32'(a.count), 0);
        chk("rst_empty", 32'(a.empty), 1);
        chk("rst_ae", 32'(a.almost_empty), 1);
        chk("rst_full", 32'(a.full), 0);
        chk("rst_af", 32'(a.almost_full), 0);
        chk("rst_ovf", 32'(a.overflow), 0);
        chk("rst_udf", 32'(a.underflow), 0);
        chk("rst_rvalid", 32'(a.rvalid), 0);
        chk("rst_rdata", 32'(a.rdata), 0);
        chk("rst_fwft_rvalid", 32'(b.rvalid), 0);
        chk("rst_fwft_rdata", 32'(b.rdata), 0);

        // Fill 16 words, flags follow count
        for (int i = 0; i < 16; i++) begin
            wr_a(8'(i));
            chk("fill_count", 32'(a.count), 32'(i + 1));
            chk("fill_ae", 32'(a.almost_empty), (i + 1 <= 2) ? 32'd1 : 32'd0);
            chk("fill_af", 32'(a.almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(a.full), (i + 1 == 16) ? 32'd1 : 32'd0);
            chk("fill_empty", 32'(a.empty), 0);
        end
        wr_a(8'hFF);
        chk("ovf_count", 32'(a.count), 16);
        chk("ovf_set", 32'(a.overflow), 1);

        // Drain, one word per cycle
        for (int i = 0; i < 16; i++) rd_a(8'(i), "drain");
        tick();
        chk("drain_rvalid_low", 32'(a.rvalid), 0);
        chk("drain_rdata_hold", 32'(a.rdata), 32'h0F);
        chk("drain_empty", 32'(a.empty), 1);
        chk("drain_udf", 32'(a.underflow), 0);
        a.err_clr = 1'b1; tick(); a.err_clr = 1'b0;
        chk("errclr_ovf", 32'(a.overflow), 0);

        // Wrap-around
        for (int i = 0; i < 10; i++) wr_a(8'(8'h40 + i));
        for (int i = 0; i < 10; i++) rd_a(8'(8'h40 + i), "wrap1");
        for (int i = 0; i < 12; i++) wr_a(8'(8'h80 + i));
        chk("wrap_count12", 32'(a.count), 12);
        for (int i = 0; i < 12; i++) rd_a(8'(8'h80 + i), "wrap2");
        chk("wrap_count0", 32'(a.count), 0);

        // Simultaneous read/write at full: write dropped, head read
        for (int i = 0; i < 16; i++) wr_a(8'(8'h20 + i));
        a.wr_rq = 1'b1; a.rd_rq = 1'b1; a.wdata = 8'hEE; tick();
        a.wr_rq = 1'b0; a.rd_rq = 1'b0;
        chk("simfull_count", 32'(a.count), 15);
        chk("simfull_ovf", 32'(a.overflow), 1);
        chk("simfull_rvalid", 32'(a.rvalid), 1);
        chk("simfull_rdata", 32'(a.rdata), 32'h20);
        for (int i = 1; i < 16; i++) rd_a(8'(8'h20 + i), "simfull_drain");
        chk("simfull_empty", 32'(a.empty), 1);

        // Simultaneous read/write at empty: read dropped, write taken
        a.wr_rq = 1'b1; a.rd_rq = 1'b1; a.wdata = 8'h77; tick();
        a.wr_rq = 1'b0; a.rd_rq = 1'b0;
        chk("simempty_count", 32'(a.count), 1);
        chk("simempty_udf", 32'(a.underflow), 1);
        chk("simempty_rvalid", 32'(a.rvalid), 0);
        rd_a(8'h77, "simempty_read");
        chk("simempty_count0", 32'(a.count), 0);

        // FWFT: word visible right after the write edge
        b.wr_rq = 1'b1; b.wdata = 8'hA5; tick(); b.wr_rq = 1'b0;
        chk("fwft_rdata", 32'(b.rdata), 32'hA5);
        chk("fwft_rvalid", 32'(b.rvalid), 1);
        chk("fwft_count", 32'(b.count), 1);
        b.rd_rq = 1'b1; tick(); b.rd_rq = 1'b0;
        chk("fwft_pop_empty", 32'(b.empty), 1);
        chk("fwft_pop_rvalid", 32'(b.rvalid), 0);

        // Reset mid-operation at count 7 with overflow still set
        for (int i = 0; i < 7; i++) wr_a(8'(8'h10 + i));
        chk("mid_count7", 32'(a.count), 7);
        chk("mid_ovf_pre", 32'(a.overflow), 1);
        rst = 1'b1; a.wr_rq = 1'b1; a.rd_rq = 1'b1; a.wdata = 8'h99; tick();
        rst = 1'b0; a.wr_rq = 1'b0; a.rd_rq = 1'b0;
        chk("mid_count", 32'(a.count), 0);
        chk("mid_empty", 32'(a.empty), 1);
        chk("mid_ovf", 32'(a.overflow), 0);
        chk("mid_udf", 32'(a.underflow), 0);
        chk("mid_rvalid", 32'(a.rvalid), 0);
        wr_a(8'h3C);
        wr_a(8'h3D);
        rd_a(8'h3C, "mid_first");
        chk("mid_count1", 32'(a.count), 1);

        // err_clr together with a new overflow: set wins
        for (int i = 0; i < 15; i++) wr_a(8'(i));
        chk("ec_full", 32'(a.full), 1);
        a.wr_rq = 1'b1; a.err_clr = 1'b1; tick(); a.wr_rq = 1'b0;
        chk("ec_set_wins", 32'(a.overflow), 1);
        tick(); a.err_clr = 1'b0;
        chk("ec_cleared", 32'(a.overflow), 0);
        chk("ec_count", 32'(a.count), 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
